// File: rtl/inst_fetch_buffer_if.sv
// Fetch-stage bundle: instruction-memory request/grant/response, decode handshake and redirect.
// Optional FETCH_FAULT_EN adds imem_err_i / inst_fault_o.
interface inst_fetch_buffer_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
`ifdef FETCH_FAULT_EN
  logic        imem_err_i;
  logic        inst_fault_o;
`endif

  // Fetch buffer side.
  modport master (
`ifdef FETCH_FAULT_EN
    input  imem_err_i,
    output inst_fault_o,
`endif
    input  redirect_i,
    input  redirect_pc_i,
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output pc_o
  );

  // Memory / decoder / redirect-source side.
  modport slave (
`ifdef FETCH_FAULT_EN
    output imem_err_i,
    input  inst_fault_o,
`endif
    output redirect_i,
    output redirect_pc_i,
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  pc_o
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: credit-limited word fetch, DEPTH-entry {pc, inst} FIFO, redirect flush.
// Optional macro FETCH_FAULT_EN stores a per-entry fetch fault flag and presents it with the head.
module inst_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic clk_i,
  input logic rst_i,
  inst_fetch_buffer_if.master bus
);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
`ifdef FETCH_FAULT_EN
  logic        fault_mem [DEPTH];
`endif

  logic [31:0] redirect_pc;
  logic        credit_ok;
  logic        req;
  logic        fire;
  logic        rsp;
  logic        push;
  logic        pop;
  logic        head_valid;

  // Handshakes: a fetch is accepted when imem_req_o && imem_gnt_i in the same cycle;
  // imem_rvalid_i returns one word per accepted fetch, in order; decode takes the head
  // when inst_valid_o && inst_ready_i. A redirect overrides all three in its cycle.
  assign redirect_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign credit_ok   = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
  assign req         = !rst_i && !bus.redirect_i && credit_ok;
  assign fire        = req && bus.imem_gnt_i;
  assign rsp         = bus.imem_rvalid_i;
  assign push        = rsp && !bus.redirect_i && (discard == '0);
  assign head_valid  = (count != '0);
  assign pop         = head_valid && bus.inst_ready_i && !bus.redirect_i;

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = fetch_pc;
  assign bus.inst_valid_o = head_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (bus.redirect_i) begin
      // Everything still in flight belongs to the old stream; a response landing
      // in this very cycle is dropped here and so is not counted again.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= outstanding - CW'(rsp);
      discard     <= outstanding - CW'(rsp);
    end else begin
      if (fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(fire) - CW'(rsp);
      if (rsp && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only observed while count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem[wr_ptr] <= bus.imem_rdata_i;
      pc_mem[wr_ptr]   <= resp_pc;
`ifdef FETCH_FAULT_EN
      fault_mem[wr_ptr] <= bus.imem_err_i;
`endif
    end
  end

  always_comb begin
    bus.inst_o = NOP;
    bus.pc_o   = 32'h0000_0000;
`ifdef FETCH_FAULT_EN
    bus.inst_fault_o = 1'b0;
`endif
    if (head_valid) begin
      bus.pc_o   = pc_mem[rd_ptr];
      bus.inst_o = inst_mem[rd_ptr];
`ifdef FETCH_FAULT_EN
      bus.inst_fault_o = fault_mem[rd_ptr];
      if (fault_mem[rd_ptr]) begin
        bus.inst_o = NOP;
      end
`endif
    end
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i) count <= CW'(DEPTH));
  a_rsp_expected : assert property (@(posedge clk_i) disable iff (rst_i)
                                    bus.imem_rvalid_i |-> (outstanding != '0));
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: directed vector table, hand sequences and a randomized run
// checked against an epoch-tagged model of the fetch stream. Build with FETCH_FAULT_EN to cover faults.
module tb_inst_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_buffer_if bus ();

  inst_fetch_buffer #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } pend_t;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rv;
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  pend_t       pend_q[$];
  logic [64:0] exp_q[$];  // {fault, pc, inst}
  vec_t        vecs[$];
  logic [31:0] model_pc;
  int          epoch;
  int          errors;
  int          checks;
`ifdef FETCH_FAULT_EN
  bit          next_err;
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.inst_ready_i  = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
`ifdef FETCH_FAULT_EN
    bus.imem_err_i = 1'b0;
    next_err       = 1'b0;
`endif
    rst = 1'b1;
    #1;
    check("rst_req", bus.imem_req_o, 1'b0);
    check("rst_valid", bus.inst_valid_o, 1'b0);
    check("rst_inst", bus.inst_o, NOP);
    check("rst_pc", bus.pc_o, 32'h0);
`ifdef FETCH_FAULT_EN
    check("rst_fault", bus.inst_fault_o, 1'b0);
`endif
    pend_q.delete();
    exp_q.delete();
    epoch++;
    model_pc = RESET_PC;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Compare the DUT against the model for this cycle, then advance the model over the edge.
  task automatic model_step(input bit gnt, input bit rv, input bit rdy, input bit redir,
                            input logic [31:0] rpc);
    bit          exp_req;
    bit          f;
    logic [64:0] h;
    pend_t       p;
    exp_req = !redir && ((exp_q.size() + pend_q.size()) < DEPTH);
    check("imem_req", bus.imem_req_o, exp_req);
    if (exp_req) check("imem_addr", bus.imem_addr_o, model_pc);
    check("inst_valid", bus.inst_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("head_pc", bus.pc_o, h[63:32]);
      check("head_inst", bus.inst_o, h[31:0]);
`ifdef FETCH_FAULT_EN
      check("head_fault", bus.inst_fault_o, h[64]);
`endif
    end else begin
      check("empty_inst", bus.inst_o, NOP);
      check("empty_pc", bus.pc_o, 32'h0);
`ifdef FETCH_FAULT_EN
      check("empty_fault", bus.inst_fault_o, 1'b0);
`endif
    end
    if (exp_q.size() != 0 && rdy && !redir) void'(exp_q.pop_front());
    if (rv) begin
      p = pend_q.pop_front();
`ifdef FETCH_FAULT_EN
      f = bus.imem_err_i;
`else
      f = 1'b0;
`endif
      if (!redir && p.epoch == epoch)
        exp_q.push_back({f, p.addr, f ? NOP : mem_word(p.addr)});
    end
    if (bus.imem_req_o && gnt) pend_q.push_back('{model_pc, epoch});
    if (redir) begin
      epoch++;
      exp_q.delete();
      model_pc = rpc & 32'hFFFF_FFFC;
    end else if (exp_req && gnt) begin
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Drive one cycle of inputs (just after the edge) and check at the falling edge.
  task automatic apply_cycle(input bit gnt, input bit rv, input bit rdy, input bit redir,
                             input logic [31:0] rpc);
    bit rv_e;
    rv_e = rv && (pend_q.size() > 0);
    bus.imem_gnt_i    = gnt;
    bus.imem_rvalid_i = rv_e;
    bus.imem_rdata_i  = rv_e ? mem_word(pend_q[0].addr) : 32'hDEAD_BEEF;
    bus.inst_ready_i  = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
`ifdef FETCH_FAULT_EN
    bus.imem_err_i = rv_e && next_err;
`endif
    @(negedge clk);
    model_step(gnt, rv_e, rdy, redir, rpc);
  endtask

  task automatic add(input bit r, input bit g, input bit v, input bit y, input bit d,
                     input logic [31:0] rpc, input bit er, input logic [31:0] ea,
                     input bit ev, input logic [31:0] ep);
    vecs.push_back('{r, g, v, y, d, rpc, er, ea, ev, ep});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    epoch  = 0;
    rst    = 1'b1;

    // rst gnt rv rdy redir rpc | req addr valid pc
    // streaming, ready always high
    add(1, 1, 0, 1, 0, 32'h0,   1, 32'h00, 0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h04, 0, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h08, 1, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h0C, 1, 32'h4);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h10, 1, 32'h8);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h14, 1, 32'hC);
    // ready low: four grants fill the FIFO, then drain
    add(1, 1, 0, 0, 0, 32'h0,   1, 32'h00, 0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,   1, 32'h04, 0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,   1, 32'h08, 1, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,   1, 32'h0C, 1, 32'h0);
    add(0, 0, 1, 0, 0, 32'h0,   0, 32'h00, 1, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,   0, 32'h00, 1, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,   0, 32'h00, 1, 32'h0);
    add(0, 1, 0, 1, 0, 32'h0,   1, 32'h10, 1, 32'h4);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h14, 1, 32'h8);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h18, 1, 32'hC);
    // two in flight, one buffered, redirect to 0x100
    add(1, 1, 0, 0, 0, 32'h0,   1, 32'h00,  0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,   1, 32'h04,  0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h0,   1, 32'h08,  1, 32'h0);
    add(0, 0, 0, 0, 1, 32'h100, 0, 32'h00,  1, 32'h0);
    add(0, 1, 1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    add(0, 0, 1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    add(0, 0, 1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,   1, 32'h104, 1, 32'h100);
    // redirect together with a response and a pop
    add(1, 1, 0, 0, 0, 32'h0,   1, 32'h00,  0, 32'h0);
    add(0, 1, 1, 0, 0, 32'h0,   1, 32'h04,  0, 32'h0);
    add(0, 0, 1, 1, 1, 32'h100, 0, 32'h00,  1, 32'h0);
    add(0, 1, 0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    // grant stall, redirect withdraws the request
    add(1, 0, 0, 1, 0, 32'h0,   1, 32'h00,  0, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,   1, 32'h00,  0, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,   1, 32'h00,  0, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,   1, 32'h00,  0, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,   1, 32'h00,  0, 32'h0);
    add(0, 0, 0, 1, 1, 32'h200, 0, 32'h00,  0, 32'h0);
    add(0, 1, 0, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
    add(0, 0, 1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
    add(0, 0, 0, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      apply_cycle(vecs[i].gnt, vecs[i].rv, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      check($sformatf("vec%0d_req", i), bus.imem_req_o, vecs[i].e_req);
      if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), bus.imem_addr_o, vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), bus.inst_valid_o, vecs[i].e_valid);
      if (vecs[i].e_valid) check($sformatf("vec%0d_pc", i), bus.pc_o, vecs[i].e_pc);
      tick();
    end

    // reset mid-stream with three fetches outstanding
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply_cycle(1, 0, 0, 0, 32'h0);
      tick();
    end
    #1;
    do_reset();
    apply_cycle(1, 0, 1, 0, 32'h0);
    check("rst_first_req", bus.imem_req_o, 1'b1);
    check("rst_first_addr", bus.imem_addr_o, RESET_PC);
    tick();

`ifdef FETCH_FAULT_EN
    // error response for the word at 0x8 only
    do_reset();
    apply_cycle(1, 0, 0, 0, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      next_err = (k == 2);
      apply_cycle(1, 1, 0, 0, 32'h0);
      tick();
    end
    next_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply_cycle(0, 0, 1, 0, 32'h0);
      check($sformatf("fault_pc%0d", k), bus.pc_o, 32'(4 * k));
      check($sformatf("fault_bit%0d", k), bus.inst_fault_o, k == 2);
      if (k == 2) check("fault_inst_nop", bus.inst_o, NOP);
      tick();
    end
`endif

    // randomized traffic
    do_reset();
    for (int blk = 0; blk < 16; blk++) begin
      int pg;
      int pr;
      int py;
      pg = $urandom_range(20, 100);
      pr = $urandom_range(20, 100);
      py = $urandom_range(10, 100);
      for (int i = 0; i < 250; i++) begin
        bit          g;
        bit          v;
        bit          y;
        bit          d;
        logic [31:0] rpc;
        if ($urandom_range(0, 1499) == 0) do_reset();
        g = $urandom_range(0, 99) < pg;
        v = $urandom_range(0, 99) < pr;
        y = $urandom_range(0, 99) < py;
        d = $urandom_range(0, 99) < 4;
        if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else rpc = $urandom & 32'h0000_FFFF;
`ifdef FETCH_FAULT_EN
        next_err = $urandom_range(0, 99) < 15;
`endif
        apply_cycle(g, v, y, d, rpc);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
